// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file writeback arbiter and its scoreboard.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_A,
    GNT_B
  } grant_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy scoreboard for destinations owned by in-flight multi-cycle ops.
// Read ports see only the registered vector; a same-cycle set beats a same-cycle clear.
module regfile_scoreboard
  import regfile_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_add,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_add,
  input  logic [REG_ADDR_W-1:0] rs1_add,
  output logic                  rs1_busy,
  input  logic [REG_ADDR_W-1:0] rs2_add,
  output logic                  rs2_busy,
  input  logic [REG_ADDR_W-1:0] chk_add,
  output logic                  chk_ready
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_add] = 1'b0;
    if (set_en && (set_add != REG_X0)) busy_d[set_add] = 1'b1;
    busy_d[REG_X0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking '<='; this vector is control state, so it is reset
  // (unlike a data RAM) to avoid phantom busy bits after power-up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

  assign rs1_busy  = busy_q[rs1_add];
  assign rs2_busy  = busy_q[rs2_add];
  assign chk_ready = ~busy_q[chk_add];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register file's single write port between pipeline writeback (A) and a
// multi-cycle unit (B), with a starvation guard for B and a busy scoreboard for decode.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int MAX_WAIT    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_valid,
  input  logic [REG_ADDR_W-1:0]  a_add,
  input  logic [WORD_LENGTH-1:0] a_data,
  output logic                   a_stall,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [REG_ADDR_W-1:0]  b_add,
  input  logic [WORD_LENGTH-1:0] b_data,
  input  logic                   issue_valid,
  input  logic [REG_ADDR_W-1:0]  issue_add,
  output logic                   issue_ready,
  input  logic [REG_ADDR_W-1:0]  add_rs1,
  input  logic [REG_ADDR_W-1:0]  add_rs2,
  output logic                   busy_rs1,
  output logic                   busy_rs2,
  output logic                   write_enable,
  output logic [REG_ADDR_W-1:0]  write_add,
  output logic [WORD_LENGTH-1:0] write_data
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  grant_e                 grant;
  logic [3:0]             wait_cnt_q, wait_cnt_d;
  logic                   we_q, we_d;
  logic [REG_ADDR_W-1:0]  add_q, add_d;
  logic [WORD_LENGTH-1:0] data_q, data_d;

  always_comb begin
    grant = GNT_NONE;
    if (b_valid && (wait_cnt_q == MAX_WAIT_C)) grant = GNT_B;
    else if (a_valid)                          grant = GNT_A;
    else if (b_valid)                          grant = GNT_B;
  end

  assign a_stall = a_valid && (grant != GNT_A);
  assign b_ready = (grant == GNT_B);

  // Counts consecutive refusals of a pending B request; saturates so FORCE_B stays asserted.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!b_valid || b_ready)         wait_cnt_d = '0;
    else if (wait_cnt_q != MAX_WAIT_C) wait_cnt_d = wait_cnt_q + 4'd1;
  end

  // x0 writes still consume the slot; only the enable is suppressed.
  always_comb begin
    we_d   = 1'b0;
    add_d  = add_q;
    data_d = data_q;
    case (grant)
      GNT_A: begin
        we_d   = (a_add != REG_X0);
        add_d  = a_add;
        data_d = a_data;
      end
      GNT_B: begin
        we_d   = (b_add != REG_X0);
        add_d  = b_add;
        data_d = b_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_q <= '0;
      we_q       <= 1'b0;
      add_q      <= '0;
      data_q     <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      we_q       <= we_d;
      add_q      <= add_d;
      data_q     <= data_d;
    end
  end

  assign write_enable = we_q;
  assign write_add    = add_q;
  assign write_data   = data_q;

  regfile_scoreboard u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_en    (issue_valid && issue_ready),
    .set_add   (issue_add),
    .clr_en    (b_valid && b_ready),
    .clr_add   (b_add),
    .rs1_add   (add_rs1),
    .rs1_busy  (busy_rs1),
    .rs2_add   (add_rs2),
    .rs2_busy  (busy_rs2),
    .chk_add   (issue_add),
    .chk_ready (issue_ready)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a behavioural model of the arbitration and scoreboard rules.
module tb_regfile_wb_arbiter;

  localparam int W  = 32;
  localparam int MW = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         a_valid, b_valid, issue_valid;
  logic [4:0]   a_add, b_add, issue_add, add_rs1, add_rs2;
  logic [W-1:0] a_data, b_data;
  logic         a_stall, b_ready, issue_ready, busy_rs1, busy_rs2;
  logic         write_enable;
  logic [4:0]   write_add;
  logic [W-1:0] write_data;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.WORD_LENGTH(W), .MAX_WAIT(MW)) dut (
    .clk          (clk),
    .rst          (rst),
    .a_valid      (a_valid),
    .a_add        (a_add),
    .a_data       (a_data),
    .a_stall      (a_stall),
    .b_valid      (b_valid),
    .b_ready      (b_ready),
    .b_add        (b_add),
    .b_data       (b_data),
    .issue_valid  (issue_valid),
    .issue_add    (issue_add),
    .issue_ready  (issue_ready),
    .add_rs1      (add_rs1),
    .add_rs2      (add_rs2),
    .busy_rs1     (busy_rs1),
    .busy_rs2     (busy_rs2),
    .write_enable (write_enable),
    .write_add    (write_add),
    .write_data   (write_data)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state
  bit         m_busy [32];
  int         m_refused;
  bit         m_we;
  logic [4:0] m_add;
  logic [W-1:0] m_data;
  bit         m_wd_known;
  int         m_q[$];
  bit         last_a_stall, last_b_acc, last_iss_hold;

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_refused     = 0;
    m_we          = 1'b0;
    m_add         = '0;
    m_data        = '0;
    m_wd_known    = 1'b1;
    m_q.delete();
    last_a_stall  = 1'b0;
    last_b_acc    = 1'b1;
    last_iss_hold = 1'b0;
  endtask

  task automatic set_idle();
    a_valid = 0; a_add = 0; a_data = 0;
    b_valid = 0; b_add = 0; b_data = 0;
    issue_valid = 0; issue_add = 0;
    add_rs1 = 0; add_rs2 = 0;
  endtask

  // Settle, compare all outputs against the model, then advance the model past the next edge.
  task automatic eval();
    bit force_b, g_a, g_b, iss_ok;
    #1;
    force_b = b_valid && (m_refused >= MW);
    g_a     = !force_b && a_valid;
    g_b     = b_valid && !g_a;
    iss_ok  = !m_busy[issue_add];

    check("a_stall", a_stall, a_valid && !g_a);
    check("b_ready", b_ready, g_b);
    check("issue_ready", issue_ready, iss_ok);
    check("busy_rs1", busy_rs1, m_busy[add_rs1]);
    check("busy_rs2", busy_rs2, m_busy[add_rs2]);
    check("write_enable", write_enable, m_we);
    if (m_wd_known) begin
      check("write_add", write_add, m_add);
      check("write_data", write_data, m_data);
    end

    if (b_valid && !g_b) m_refused = (m_refused < MW) ? m_refused + 1 : MW;
    else                 m_refused = 0;

    if (g_a) begin
      m_we = (a_add != 0); m_add = a_add; m_data = a_data; m_wd_known = (a_add != 0);
    end else if (g_b) begin
      m_we = (b_add != 0); m_add = b_add; m_data = b_data; m_wd_known = (b_add != 0);
    end else begin
      m_we = 1'b0;
    end

    if (g_b) begin
      if (b_add != 0) m_busy[b_add] = 1'b0;
      if (m_q.size() > 0 && m_q[0] == int'(b_add)) void'(m_q.pop_front());
    end
    if (issue_valid && iss_ok) begin
      if (issue_add != 0) m_busy[issue_add] = 1'b1;
      m_q.push_back(int'(issue_add));
    end

    last_a_stall  = a_valid && !g_a;
    last_b_acc    = g_b;
    last_iss_hold = issue_valid && !iss_ok;
  endtask

  task automatic adv();
    @(negedge clk);
  endtask

  initial begin
    set_idle();
    model_reset();
    rst = 1'b0;
    #3;
    check("rst_we", write_enable, 0);
    check("rst_add", write_add, 0);
    check("rst_data", write_data, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // A only
    a_valid = 1; a_add = 5'd5; a_data = 32'hDEAD_BEEF;
    eval(); check("t2_a_stall", a_stall, 0); adv();
    set_idle();
    eval();
    check("t2_we", write_enable, 1);
    check("t2_add", write_add, 5);
    check("t2_data", write_data, 32'hDEAD_BEEF);
    adv();

    // Contention: A held, B pending to reg 7
    a_valid = 1; a_add = 5'd3; a_data = 32'h0000_0333;
    b_valid = 1; b_add = 5'd7; b_data = 32'h0000_0777;
    for (int i = 0; i < 4; i++) begin
      eval();
      check("t3_b_refused", b_ready, 0);
      check("t3_a_granted", a_stall, 0);
      adv();
    end
    eval();
    check("t3_b_forced", b_ready, 1);
    check("t3_a_stalled", a_stall, 1);
    adv();
    b_valid = 0;
    eval();
    check("t3_a_regrant", a_stall, 0);
    check("t3_we7", write_enable, 1);
    check("t3_add7", write_add, 7);
    check("t3_data7", write_data, 32'h0000_0777);
    adv();
    a_valid = 0;
    eval(); check("t3_add3", write_add, 3); adv();

    // Scoreboard: issue 9, then B completes to 9
    set_idle();
    issue_valid = 1; issue_add = 5'd9;
    eval(); check("t4_issue_ok", issue_ready, 1); adv();
    issue_valid = 0; add_rs1 = 5'd9;
    eval();
    check("t4_busy9", busy_rs1, 1);
    check("t4_issue_blocked", issue_ready, 0);
    adv();
    b_valid = 1; b_add = 5'd9; b_data = 32'h0000_0099;
    eval();
    check("t4_b_ready", b_ready, 1);
    check("t4_busy_still", busy_rs1, 1);
    adv();
    b_valid = 0;
    eval();
    check("t4_we9", write_enable, 1);
    check("t4_add9", write_add, 9);
    check("t4_busy_clear", busy_rs1, 0);
    adv();

    // Set wins over clear on the same index
    b_valid = 1; b_add = 5'd9; b_data = 32'h0000_0055;
    issue_valid = 1; issue_add = 5'd9;
    eval();
    check("t5_b_ready", b_ready, 1);
    check("t5_issue_ok", issue_ready, 1);
    adv();
    b_valid = 0; issue_valid = 0;
    eval(); check("t5_busy_set", busy_rs1, 1); adv();
    b_valid = 1; b_add = 5'd9;
    eval(); adv();
    b_valid = 0;

    // x0 handling
    b_valid = 1; b_add = 5'd0; b_data = 32'h0000_0123;
    eval(); check("t6_b_ready", b_ready, 1); adv();
    b_valid = 0;
    eval(); check("t6_we_x0", write_enable, 0); adv();
    issue_valid = 1; issue_add = 5'd0; add_rs1 = 5'd0;
    eval(); check("t6_issue_x0", issue_ready, 1); adv();
    issue_valid = 0;
    eval(); check("t6_busy_x0", busy_rs1, 0); adv();

    // Reset while a write is being presented
    issue_valid = 1; issue_add = 5'd12;
    a_valid = 1; a_add = 5'd4; a_data = 32'h0000_A5A5;
    eval(); adv();
    set_idle(); add_rs2 = 5'd12;
    eval();
    check("t1_we_before", write_enable, 1);
    check("t1_busy12_before", busy_rs2, 1);
    #1 rst = 1'b0;
    #1;
    check("t1_we_rst", write_enable, 0);
    check("t1_add_rst", write_add, 0);
    check("t1_data_rst", write_data, 0);
    for (int r = 0; r < 32; r++) begin
      add_rs1 = 5'(r);
      #1 check("t1_busy_rst", busy_rs1, 0);
    end
    model_reset();
    set_idle();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    eval(); check("t1_no_write", write_enable, 0); adv();
    eval(); check("t1_no_write2", write_enable, 0); adv();

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!(a_valid && last_a_stall)) begin
        a_valid = 1'($urandom % 2);
        a_add   = 5'($urandom_range(1, 31));
        if (m_busy[a_add]) a_add = 5'd0;
        a_data  = $urandom;
      end
      if (!(b_valid && !last_b_acc)) begin
        if (m_q.size() > 0 && ($urandom % 3) != 0) begin
          b_valid = 1'b1;
          b_add   = 5'(m_q[0]);
          b_data  = $urandom;
        end else begin
          b_valid = 1'b0;
        end
      end
      if (!(issue_valid && last_iss_hold)) begin
        issue_valid = (($urandom % 3) == 0) && (m_q.size() < 4);
        issue_add   = 5'($urandom_range(0, 15));
      end
      add_rs1 = 5'($urandom_range(0, 15));
      add_rs2 = 5'($urandom_range(0, 15));
      eval();
      adv();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
